note_player: RTL

Tone-generation stage directly downstream of the song reader. It accepts one note per `new_note` handshake, plays it for `duration` beats by advancing a phase accumulator at the audio sample rate, then pulses `note_done` so the song reader advances its address and issues the next note. Its phase output feeds the waveform ROM and codec stage.

---
 rtl/note_player.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/note_player.sv
// Tone generator: plays one note per new_note handshake for `duration` beats, stepping a
// phase accumulator on each audio sample tick, then pulses note_done to request the next note.
module note_player #(
  parameter int unsigned PHASE_W = 22,
  parameter int unsigned STEP_W  = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       play,
  input  logic       new_note,
  input  logic [5:0] note,
  input  logic [5:0] duration,
  input  logic       beat,
  input  logic       sample_tick,
  output logic       note_done,
  output logic       busy,
  output logic       sample_valid,
  output logic [9:0] phase_out
);

  typedef enum logic [1:0] {
    StIdle,
    StPlaying,
    StDone
  } state_e;

  // The step table below is tabulated for a 22-bit accumulator; other widths rescale it.
  localparam int unsigned TableW = 22;
  localparam int unsigned ShUp   = (PHASE_W >= TableW) ? (PHASE_W - TableW) : 0;
  localparam int unsigned ShDn   = (PHASE_W < TableW) ? (TableW - PHASE_W) : 0;
  localparam logic [31:0] Rnd    = (32'd1 << ShDn) >> 1;

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [5:0]          remain_q, remain_d;
  logic [PHASE_W-1:0]  phase_q, phase_d;
  logic                note_done_q, note_done_d;
  logic                sample_valid_q, sample_valid_d;
  logic [STEP_W-1:0]   step_lut;
  logic                load;

  // Phase increment per 48 kHz sample for key n at 22-bit scale; key 49 is A4 = 440 Hz.
  function automatic logic [16:0] step_rom(input logic [5:0] n);
    logic [16:0] s;
    case (n)
      6'd1:  s = 17'd2403;
      6'd2:  s = 17'd2546;
      6'd3:  s = 17'd2697;
      6'd4:  s = 17'd2858;
      6'd5:  s = 17'd3028;
      6'd6:  s = 17'd3208;
      6'd7:  s = 17'd3398;
      6'd8:  s = 17'd3600;
      6'd9:  s = 17'd3815;
      6'd10: s = 17'd4041;
      6'd11: s = 17'd4282;
      6'd12: s = 17'd4536;
      6'd13: s = 17'd4806;
      6'd14: s = 17'd5092;
      6'd15: s = 17'd5395;
      6'd16: s = 17'd5715;
      6'd17: s = 17'd6055;
      6'd18: s = 17'd6415;
      6'd19: s = 17'd6797;
      6'd20: s = 17'd7201;
      6'd21: s = 17'd7629;
      6'd22: s = 17'd8083;
      6'd23: s = 17'd8563;
      6'd24: s = 17'd9072;
      6'd25: s = 17'd9612;
      6'd26: s = 17'd10184;
      6'd27: s = 17'd10789;
      6'd28: s = 17'd11431;
      6'd29: s = 17'd12110;
      6'd30: s = 17'd12830;
      6'd31: s = 17'd13593;
      6'd32: s = 17'd14402;
      6'd33: s = 17'd15258;
      6'd34: s = 17'd16165;
      6'd35: s = 17'd17127;
      6'd36: s = 17'd18145;
      6'd37: s = 17'd19224;
      6'd38: s = 17'd20367;
      6'd39: s = 17'd21578;
      6'd40: s = 17'd22861;
      6'd41: s = 17'd24221;
      6'd42: s = 17'd25661;
      6'd43: s = 17'd27187;
      6'd44: s = 17'd28803;
      6'd45: s = 17'd30516;
      6'd46: s = 17'd32331;
      6'd47: s = 17'd34253;
      6'd48: s = 17'd36290;
      6'd49: s = 17'd38447;
      6'd50: s = 17'd40734;
      6'd51: s = 17'd43156;
      6'd52: s = 17'd45722;
      6'd53: s = 17'd48441;
      6'd54: s = 17'd51322;
      6'd55: s = 17'd54373;
      6'd56: s = 17'd57607;
      6'd57: s = 17'd61032;
      6'd58: s = 17'd64661;
      6'd59: s = 17'd68506;
      6'd60: s = 17'd72580;
      6'd61: s = 17'd76896;
      6'd62: s = 17'd81468;
      6'd63: s = 17'd86313;
      default: s = 17'd0;
    endcase
    return s;
  endfunction

  always_comb begin
    step_lut = STEP_W'(((32'(step_rom(note)) + Rnd) >> ShDn) << ShUp);
  end

  always_comb begin
    state_d        = state_q;
    step_d         = step_q;
    remain_d       = remain_q;
    phase_d        = phase_q;
    sample_valid_d = 1'b0;
    load           = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (new_note) load = 1'b1;
      end
      StPlaying: begin
        // A new note always wins; the aborted note never reports done.
        if (new_note) begin
          load = 1'b1;
        end else if (play && beat) begin
          if (remain_q == 6'd1) state_d = StDone;
          else                  remain_d = remain_q - 6'd1;
        end else if (play && sample_tick) begin
          phase_d        = phase_q + PHASE_W'(step_q);
          sample_valid_d = 1'b1;
        end
      end
      StDone: begin
        if (new_note) load = 1'b1;
        else          state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      step_d   = step_lut;
      remain_d = duration;
      phase_d  = '0;
      state_d  = (duration == 6'd0) ? StDone : StPlaying;
    end

    note_done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      step_q         <= '0;
      remain_q       <= '0;
      phase_q        <= '0;
      note_done_q    <= 1'b0;
      sample_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      step_q         <= step_d;
      remain_q       <= remain_d;
      phase_q        <= phase_d;
      note_done_q    <= note_done_d;
      sample_valid_q <= sample_valid_d;
    end
  end

  assign note_done    = note_done_q;
  assign sample_valid = sample_valid_q;
  assign busy         = (state_q != StIdle);
  assign phase_out    = phase_q[PHASE_W-1 -: 10];

endmodule
